// File: rtl/regbank_sequencer.sv
// Single-command micro-sequencer for an 8 x 8-bit register bank: reads operands, runs an ALU op,
// writes back (r0 suppressed), waits out the bank write latency and returns result plus flags.
module regbank_sequencer #(
  parameter int unsigned WR_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_rd,
  input  logic [2:0] cmd_rs1,
  input  logic [2:0] cmd_rs2,
  input  logic [7:0] cmd_imm,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       busy,
  output logic [2:0] rf_ra1,
  output logic [2:0] rf_ra2,
  input  logic [7:0] rf_rd1,
  input  logic [7:0] rf_rd2,
  output logic       rf_we3,
  output logic [2:0] rf_wa3,
  output logic [7:0] rf_wd3
);

  localparam logic [2:0] OpNop = 3'd0;
  localparam logic [2:0] OpLdi = 3'd1;
  localparam logic [2:0] OpAdd = 3'd2;
  localparam logic [2:0] OpSub = 3'd3;
  localparam logic [2:0] OpAnd = 3'd4;
  localparam logic [2:0] OpOr  = 3'd5;
  localparam logic [2:0] OpXor = 3'd6;
  localparam logic [2:0] OpRd  = 3'd7;

  typedef enum logic [2:0] {StIdle, StExec, StWrite, StSettle, StResp} state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, rd_q, rs1_q, rs2_q;
  logic [7:0] imm_q;
  logic [7:0] res_q, res_d;
  logic       zero_q, zero_d, carry_q, carry_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] wa_q, wa_d;
  logic [7:0] wd_q, wd_d;
  logic       capture;

  logic [8:0] alu_ext;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic       writes_back;

  always_comb begin
    alu_ext   = 9'd0;
    alu_res   = 8'd0;
    alu_carry = 1'b0;
    case (op_q)
      OpNop: alu_res = 8'd0;
      OpLdi: alu_res = imm_q;
      OpAdd: begin
        alu_ext   = {1'b0, rf_rd1} + {1'b0, rf_rd2};
        alu_res   = alu_ext[7:0];
        alu_carry = alu_ext[8];
      end
      OpSub: begin
        // Bit 8 of the 9-bit difference is the borrow (rd1 < rd2).
        alu_ext   = {1'b0, rf_rd1} - {1'b0, rf_rd2};
        alu_res   = alu_ext[7:0];
        alu_carry = alu_ext[8];
      end
      OpAnd:   alu_res = rf_rd1 & rf_rd2;
      OpOr:    alu_res = rf_rd1 | rf_rd2;
      OpXor:   alu_res = rf_rd1 ^ rf_rd2;
      default: alu_res = rf_rd1;
    endcase
  end

  assign writes_back = (op_q != OpNop) && (op_q != OpRd) && (rd_q != 3'd0);

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    wa_d    = wa_q;
    wd_d    = wd_q;
    capture = 1'b0;
    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          capture = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        res_d   = alu_res;
        carry_d = alu_carry;
        zero_d  = (alu_res == 8'd0);
        if (writes_back) begin
          state_d = StWrite;
          wa_d    = rd_q;
          wd_d    = alu_res;
        end else begin
          state_d = StResp;
        end
      end
      StWrite: begin
        state_d = StSettle;
        cnt_d   = 3'(WR_LAT);
      end
      StSettle: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 3'd0;
      rd_q    <= 3'd0;
      rs1_q   <= 3'd0;
      rs2_q   <= 3'd0;
      imm_q   <= 8'd0;
      res_q   <= 8'd0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= 3'd0;
      wa_q    <= 3'd0;
      wd_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      if (capture) begin
        op_q  <= cmd_op;
        rd_q  <= cmd_rd;
        rs1_q <= cmd_rs1;
        rs2_q <= cmd_rs2;
        imm_q <= cmd_imm;
      end
    end
  end

  // Write address/data are registered so they hold their last values outside WRITE.
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = res_q;
  assign rsp_zero  = zero_q;
  assign rsp_carry = carry_q;
  assign rf_ra1    = rs1_q;
  assign rf_ra2    = rs2_q;
  assign rf_we3    = (state_q == StWrite);
  assign rf_wa3    = wa_q;
  assign rf_wd3    = wd_q;

endmodule

// File: tb/tb_regbank_sequencer.sv
// Bench for regbank_sequencer: behavioural register bank with write latency, directed vector table,
// hand-written backpressure/reset sequences and random commands checked against a reference model.
module tb_regbank_sequencer;

  localparam int unsigned WR_LAT = 2;
  localparam int WL = 3 + WR_LAT;
  localparam int NL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_op = '0, cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [7:0] cmd_imm = '0;
  logic       rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_zero, rsp_carry, busy;
  logic [2:0] rf_ra1, rf_ra2, rf_wa3;
  logic [7:0] rf_rd1, rf_rd2, rf_wd3;
  logic       rf_we3;

  always #5 clk = ~clk;

  regbank_sequencer #(.WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_rd(cmd_rd),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .busy(busy),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3)
  );

  // Register bank: a write becomes visible WR_LAT edges after the edge that samples rf_we3.
  logic [7:0] bank [8] = '{default: 8'h00};
  logic       pipe_we [WR_LAT] = '{default: 1'b0};
  logic [2:0] pipe_wa [WR_LAT] = '{default: 3'd0};
  logic [7:0] pipe_wd [WR_LAT] = '{default: 8'h00};
  int         we_cnt = 0;
  logic [2:0] we_wa = '0;
  logic [7:0] we_wd = '0;

  assign rf_rd1 = (rf_ra1 == 3'd0) ? 8'h00 : bank[rf_ra1];
  assign rf_rd2 = (rf_ra2 == 3'd0) ? 8'h00 : bank[rf_ra2];

  always @(posedge clk) begin
    pipe_we[0] <= rf_we3;
    pipe_wa[0] <= rf_wa3;
    pipe_wd[0] <= rf_wd3;
    for (int i = 1; i < int'(WR_LAT); i++) begin
      pipe_we[i] <= pipe_we[i-1];
      pipe_wa[i] <= pipe_wa[i-1];
      pipe_wd[i] <= pipe_wd[i-1];
    end
    if (pipe_we[WR_LAT-1]) bank[pipe_wa[WR_LAT-1]] <= pipe_wd[WR_LAT-1];
    if (rf_we3) begin
      we_cnt <= we_cnt + 1;
      we_wa  <= rf_wa3;
      we_wd  <= rf_wd3;
    end
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] ref_regs [8] = '{default: 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural meaning of each opcode.
  function automatic void model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] imm, output logic [7:0] d, output logic c,
                                output logic wr);
    int s;
    c  = 1'b0;
    wr = 1'b1;
    d  = 8'h00;
    case (op)
      3'd0: wr = 1'b0;
      3'd1: d = imm;
      3'd2: begin s = int'(a) + int'(b); d = 8'(s); c = (s > 255); end
      3'd3: begin d = a - b; c = (a < b); end
      3'd4: d = a & b;
      3'd5: d = a | b;
      3'd6: d = a ^ b;
      default: begin d = a; wr = 1'b0; end
    endcase
  endfunction

  task automatic predict(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm,
                         output logic [7:0] d, output logic z, output logic c, output int lat);
    logic wr;
    model(op, ref_regs[rs1], ref_regs[rs2], imm, d, c, wr);
    z   = (d == 8'h00);
    lat = (wr && rd != 3'd0) ? WL : NL;
  endtask

  task automatic commit(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm);
    logic [7:0] d;
    logic c, wr;
    model(op, ref_regs[rs1], ref_regs[rs2], imm, d, c, wr);
    if (wr && rd != 3'd0) ref_regs[rd] = d;
  endtask

  task automatic run_cmd(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm,
                         input int stall, output logic [7:0] d, output logic z,
                         output logic c, output int lat, output int wes, output int acc_wait);
    int we0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    acc_wait = 0;
    while (!cmd_ready && acc_wait < 50) begin
      @(negedge clk);
      acc_wait++;
    end
    we0 = we_cnt;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    d = rsp_data; z = rsp_zero; c = rsp_carry;
    for (int i = 0; i < stall; i++) begin
      chk("rsp_hold_stable", {rsp_valid, cmd_ready, rsp_data, rsp_zero, rsp_carry},
          {1'b1, 1'b0, d, z, c});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    wes = we_cnt - we0;
  endtask

  task automatic exec_check(input string tag, input logic [2:0] op, rd, rs1, rs2,
                            input logic [7:0] imm, input int stall, input logic [7:0] ed,
                            input logic ez, input logic ec, input int elat);
    logic [7:0] d;
    logic z, c;
    int lat, wes, aw;
    run_cmd(op, rd, rs1, rs2, imm, stall, d, z, c, lat, wes, aw);
    chk({tag, "_data"}, 32'(d), 32'(ed));
    chk({tag, "_zero"}, 32'(z), 32'(ez));
    chk({tag, "_carry"}, 32'(c), 32'(ec));
    chk({tag, "_latency"}, lat, elat);
    chk({tag, "_we_pulses"}, wes, (elat == WL) ? 1 : 0);
    if (wes == 1) begin
      chk({tag, "_wa"}, 32'(we_wa), 32'(rd));
      chk({tag, "_wd"}, 32'(we_wd), 32'(ed));
    end
  endtask

  typedef struct {
    logic [2:0] op, rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] d;
    logic       z, c;
    int         lat;
  } vec_t;

  vec_t tbl [16];

  initial begin
    logic [7:0] d;
    logic z, c;
    int lat, wes, aw, n, bad;
    logic [2:0] op, rd, rs1, rs2;
    logic [7:0] imm;

    tbl[0]  = '{3'd1, 3'd3, 3'd0, 3'd0, 8'h5A, 8'h5A, 1'b0, 1'b0, WL}; // LDI r3
    tbl[1]  = '{3'd7, 3'd0, 3'd3, 3'd0, 8'h00, 8'h5A, 1'b0, 1'b0, NL}; // RD r3
    tbl[2]  = '{3'd1, 3'd1, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, WL};
    tbl[3]  = '{3'd1, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 1'b0, WL};
    tbl[4]  = '{3'd2, 3'd4, 3'd1, 3'd2, 8'h00, 8'h10, 1'b0, 1'b1, WL}; // ADD carry
    tbl[5]  = '{3'd3, 3'd5, 3'd4, 3'd4, 8'h00, 8'h00, 1'b1, 1'b0, WL}; // SUB to zero
    tbl[6]  = '{3'd1, 3'd6, 3'd0, 3'd0, 8'h01, 8'h01, 1'b0, 1'b0, WL};
    tbl[7]  = '{3'd3, 3'd7, 3'd0, 3'd6, 8'h00, 8'hFF, 1'b0, 1'b1, WL}; // 0 - 1 borrow
    tbl[8]  = '{3'd1, 3'd0, 3'd0, 3'd0, 8'h77, 8'h77, 1'b0, 1'b0, NL}; // LDI r0
    tbl[9]  = '{3'd7, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0, NL}; // RD r0
    tbl[10] = '{3'd4, 3'd3, 3'd1, 3'd3, 8'h00, 8'h50, 1'b0, 1'b0, WL};
    tbl[11] = '{3'd5, 3'd5, 3'd2, 3'd3, 8'h00, 8'h70, 1'b0, 1'b0, WL};
    tbl[12] = '{3'd6, 3'd4, 3'd1, 3'd1, 8'h00, 8'h00, 1'b1, 1'b0, WL};
    tbl[13] = '{3'd0, 3'd2, 3'd1, 3'd2, 8'hAA, 8'h00, 1'b1, 1'b0, NL}; // NOP
    tbl[14] = '{3'd7, 3'd0, 3'd3, 3'd0, 8'h00, 8'h50, 1'b0, 1'b0, NL};
    tbl[15] = '{3'd2, 3'd0, 3'd1, 3'd1, 8'h00, 8'hE0, 1'b0, 1'b1, NL}; // ADD to r0

    #12;
    chk("reset_state", {cmd_ready, busy, rsp_valid, rf_we3, rsp_data, rsp_zero, rsp_carry,
                        rf_wa3, rf_wd3, rf_ra1, rf_ra2},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0});
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      exec_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
                 tbl[i].imm, (i == 4) ? 4 : 0, tbl[i].d, tbl[i].z, tbl[i].c, tbl[i].lat);
      commit(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
    end

    // Backpressure with a second command held on the command channel.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_rd = 3'd6; cmd_imm = 8'h33;
    @(posedge clk);
    #1 cmd_op = 3'd7; cmd_rs1 = 3'd6;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_first_data", {rsp_valid, rsp_data}, {1'b1, 8'h33});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_stall", {rsp_valid, cmd_ready, busy, rsp_data, rsp_zero, rsp_carry},
          {1'b1, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0});
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    chk("bp_idle_after_hs", {cmd_ready, busy}, 2'b10);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("bp_accept_next", {cmd_ready, busy}, 2'b01);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    chk("bp_second_data", {rsp_valid, rsp_data}, {1'b1, 8'h33});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    ref_regs[6] = 8'h33;

    // Reset while an ADD is settling; its write has already gone to the bank.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_rd = 3'd4; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("settle_busy", {busy, rsp_valid, rf_we3}, 3'b100);
    rst = 1'b1;
    #1;
    chk("mid_cycle_reset", {cmd_ready, busy, rsp_valid, rf_we3}, 4'b1000);
    commit(3'd2, 3'd4, 3'd1, 3'd2, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid || rf_we3 || busy) bad++;
      @(negedge clk);
    end
    chk("quiet_after_reset", bad, 0);
    run_cmd(3'd7, 3'd0, 3'd4, 3'd0, 8'h00, 0, d, z, c, lat, wes, aw);
    chk("post_reset_accept_wait", aw, 0);
    chk("post_reset_rd", {d, z, c}, {8'h10, 1'b0, 1'b0});
    chk("post_reset_latency", lat, NL);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] ed;
      logic ez, ec;
      int el;
      op  = 3'($urandom_range(0, 7));
      rd  = 3'($urandom_range(0, 7));
      rs1 = 3'($urandom_range(0, 7));
      rs2 = 3'($urandom_range(0, 7));
      imm = 8'($urandom_range(0, 255));
      predict(op, rd, rs1, rs2, imm, ed, ez, ec, el);
      exec_check($sformatf("rnd%0d", i), op, rd, rs1, rs2, imm, $urandom_range(0, 2),
                 ed, ez, ec, el);
      commit(op, rd, rs1, rs2, imm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regbank_sequencer.md
Name: regbank_sequencer

Overview:
- Single-command micro-sequencer in front of the 8 x 8-bit register bank (3-bit addresses, two combinational read ports, one write port, r0 hard-wired to zero).
- Accepts one command at a time over a valid/ready interface, reads operands, runs an 8-bit ALU op and writes the result back. Writes to r0 are suppressed.
- Waits out the bank's multi-cycle write latency, then returns the result with flags over a valid/ready response channel.

Parameters:
- WR_LAT, 2, clock edges between the bank write-enable edge and the written value appearing on the read ports; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at posedge
- cmd_op  in  3  000 NOP, 001 LDI, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 RD
- cmd_rd  in  3  destination register
- cmd_rs1  in  3  source 1
- cmd_rs2  in  3  source 2
- cmd_imm  in  8  immediate for LDI
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready at posedge
- rsp_data  out  8  result
- rsp_zero  out  1  rsp_data == 0
- rsp_carry  out  1  ADD carry-out / SUB borrow; 0 for other ops
- busy  out  1  high in every state except IDLE
- rf_ra1  out  3  bank read address 1
- rf_ra2  out  3  bank read address 2
- rf_rd1  in  8  bank read data 1
- rf_rd2  in  8  bank read data 2
- rf_we3  out  1  bank write enable
- rf_wa3  out  3  bank write address
- rf_wd3  out  8  bank write data

Behaviour:
- Reset (async, any state): state=IDLE; rsp_valid, rsp_data, rsp_zero, rsp_carry, rf_we3, rf_wa3, rf_wd3, rf_ra1, rf_ra2 and the settle counter all 0. cmd_ready=1 and busy=0 once in IDLE. Any in-flight command is dropped with no response.
- FSM states: IDLE, EXEC, WRITE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On handshake, register op, rd, rs1, rs2 and imm, then go to EXEC.
- EXEC (1 cycle):
  - rf_ra1=rs1_q, rf_ra2=rs2_q; rf_rd1/rf_rd2 are sampled in this same cycle.
  - Result is registered at the end of EXEC:
    - LDI = imm
    - ADD = rd1+rd2 mod 256, carry = bit 8
    - SUB = rd1-rd2 mod 256, carry = 1 iff rd1<rd2
    - AND/OR/XOR bitwise
    - RD = rd1
    - NOP = 0
  - zero is computed from the 8-bit result.
  - Next state: WRITE if op is in {LDI, ADD, SUB, AND, OR, XOR} and rd_q != 0; otherwise RESP.
- WRITE (1 cycle): rf_we3=1, rf_wa3=rd_q, rf_wd3=result. Next: SETTLE, with counter loaded to WR_LAT.
- SETTLE: counter decrements each cycle; at 1, go to RESP. rf_we3=0 throughout.
- RESP:
  - rsp_valid=1; rsp_data, rsp_zero and rsp_carry are held stable until handshake.
  - On handshake, go to IDLE. cmd_ready=0 while in RESP.
- rf_we3 is high exactly one cycle per write command and is never high with rf_wa3=0.
- Outside WRITE: rf_we3=0; rf_wa3 and rf_wd3 hold their last values.
- Timing, with the accept edge = E0:
  - Write command: rsp_valid rises at cycle 3+WR_LAT after E0 (cycle 5 for WR_LAT=2).
  - NOP, RD, or destination r0: rsp_valid rises at cycle 2.
- Next-command rule: the next command is accepted no earlier than the cycle after the response handshake. Any later read therefore sees the prior write.
- cmd_valid while not in IDLE is ignored; the command is neither captured nor lost, and the requester keeps holding it.
- rsp_zero and rsp_carry are updated only at EXEC; for LDI, AND, OR, XOR, RD and NOP, carry=0.

Test Plan:
- Reset: assert rst mid-cycle -> cmd_ready=1, busy=0, rsp_valid=0, rf_we3=0 immediately.
- LDI rd=3 imm=0x5A -> rf_we3 high one cycle with wa3=3, wd3=0x5A; rsp_valid at cycle 5 with data 0x5A, zero=0. Then RD rs1=3 -> rsp at cycle 2 with data 0x5A.
- ADD r4=r1+r2 with r1=0xF0, r2=0x20 -> 0x10, carry=1, zero=0. SUB r5=r4-r4 -> 0x00, zero=1, carry=0. SUB 0x00-0x01 -> 0xFF, carry=1.
- LDI rd=0 imm=0x77 -> rf_we3 never asserted; rsp at cycle 2 with data 0x77. RD rs1=0 -> 0x00, zero=1.
- Backpressure: hold rsp_ready=0 for 4 cycles -> rsp_valid, data and flags stable; cmd_ready=0. A concurrently held cmd_valid is accepted only the cycle after the rsp handshake.
- Reset during SETTLE of an ADD -> FSM goes to IDLE; no rsp_valid ever issued; rf_we3 stays 0; a new command is accepted right after reset is released.
